// File: rtl/pic_stream_bridge.sv
// Elastic FIFO bridge from the SD reader stream to the LCD pixel stream, with runtime byte swizzle.
// Define STREAM_BRIDGE_STATS_EN to add the drop_cnt and frame_cnt statistics outputs.
module pic_stream_bridge #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int BUSY_MARGIN = 2,
  parameter int FRAME_WORDS = 38400
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             swap_mode,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_trigger,
  output logic                   in_busy,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_trigger,
  input  logic                   out_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_done,
  output logic                   overflow
`ifdef STREAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic [7:0]             frame_cnt
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int FCW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FIRE, GUARD} state_e;

  function automatic logic [DATA_W-1:0] swz(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        m
  );
    logic [DATA_W-1:0] r;
    r = w;
    case (m)
      2'd1:
        for (int i = 0; i < DATA_W/16; i++) begin
          r[16*i +: 8]   = w[16*i+8 +: 8];
          r[16*i+8 +: 8] = w[16*i +: 8];
        end
      2'd2:
        for (int i = 0; i + 1 < DATA_W/16; i += 2) begin
          r[16*i +: 16]     = w[16*(i+1) +: 16];
          r[16*(i+1) +: 16] = w[16*i +: 16];
        end
      2'd3:
        for (int i = 0; i < DATA_W/8; i++)
          r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
      default: r = w;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_trigger_q, out_trigger_d;
  logic              in_busy_q, in_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              push, drop, pop;
`ifdef STREAM_BRIDGE_STATS_EN
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    push = in_trigger && (level_q != LW'(DEPTH));
    drop = in_trigger && (level_q == LW'(DEPTH));
    // A pop may start from IDLE or straight out of GUARD, giving one word per 2 cycles.
    pop  = (state_q != FIRE) && (level_q != '0) && !out_busy;

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fcnt_d        = fcnt_q;
    out_data_d    = out_data_q;
    out_trigger_d = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q | drop;
`ifdef STREAM_BRIDGE_STATS_EN
    drop_cnt_d    = drop_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
`endif

    if (push)
      wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      out_data_d    = swz(mem_q[rd_ptr_q], swap_mode);
      out_trigger_d = 1'b1;
      state_d       = FIRE;
      if (fcnt_q == FCW'(FRAME_WORDS - 1)) begin
        fcnt_d       = '0;
        frame_done_d = 1'b1;
`ifdef STREAM_BRIDGE_STATS_EN
        frame_cnt_d  = frame_cnt_q + 8'd1;
`endif
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end else begin
      case (state_q)
        FIRE:    state_d = GUARD;
        GUARD:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    level_d = level_q + LW'(push) - LW'(pop);

    if (flush) begin
      state_d       = IDLE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      fcnt_d        = '0;
      out_data_d    = out_data_q;
      out_trigger_d = 1'b0;
      frame_done_d  = 1'b0;
      overflow_d    = 1'b0;
`ifdef STREAM_BRIDGE_STATS_EN
      drop_cnt_d    = '0;
      frame_cnt_d   = frame_cnt_q;
`endif
    end

    in_busy_d = (level_d >= LW'(DEPTH - BUSY_MARGIN));
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      fcnt_q        <= '0;
      out_data_q    <= '0;
      out_trigger_q <= 1'b0;
      in_busy_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef STREAM_BRIDGE_STATS_EN
      drop_cnt_q    <= '0;
      frame_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      fcnt_q        <= fcnt_d;
      out_data_q    <= out_data_d;
      out_trigger_q <= out_trigger_d;
      in_busy_q     <= in_busy_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
`ifdef STREAM_BRIDGE_STATS_EN
      drop_cnt_q    <= drop_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign in_busy     = in_busy_q;
  assign out_data    = out_data_q;
  assign out_trigger = out_trigger_q;
  assign level       = level_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
`ifdef STREAM_BRIDGE_STATS_EN
  assign drop_cnt    = drop_cnt_q;
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pic_stream_bridge.sv
// Self-checking bench for pic_stream_bridge: vector table, corner sequences, random traffic.
// A queue-based reference model tracks contents, strobes, level, busy and frame pulses.
module tb_pic_stream_bridge;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int FW     = 8;
  localparam int LW     = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_trigger, out_busy;
  logic          in_busy, out_trigger, frame_done, overflow;
  logic [1:0]    swap_mode;
  logic [DW-1:0] in_data, out_data;
  logic [LW-1:0] level;
`ifdef STREAM_BRIDGE_STATS_EN
  logic [15:0]   drop_cnt;
  logic [7:0]    frame_cnt;
`endif

  pic_stream_bridge #(
    .DATA_W(DW), .DEPTH(DEPTH), .BUSY_MARGIN(MARGIN), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .swap_mode(swap_mode),
    .in_data(in_data), .in_trigger(in_trigger), .in_busy(in_busy),
    .out_data(out_data), .out_trigger(out_trigger), .out_busy(out_busy),
    .level(level), .frame_done(frame_done), .overflow(overflow)
`ifdef STREAM_BRIDGE_STATS_EN
    , .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_last, m_trig, m_fd;
  logic [DW-1:0] m_data;
  int            m_fcnt, m_drops, m_frames;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_swz(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'd1:    return {w[23:16], w[31:24], w[7:0], w[15:8]};
      2'd2:    return {w[15:0], w[31:16]};
      2'd3:    return {w[7:0], w[15:8], w[23:16], w[31:24]};
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_last = 0; m_trig = 0; m_fd = 0;
    m_data = '0; m_fcnt = 0; m_drops = 0; m_frames = 0;
  endtask

  task automatic tick();
    bit full, pop;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush) begin
      mq.delete();
      m_ovf = 0; m_last = 0; m_trig = 0; m_fd = 0; m_fcnt = 0; m_drops = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && !out_busy && !m_last;
      m_fd = 0;
      if (pop) begin
        m_data = ref_swz(mq.pop_front(), swap_mode);
        if (m_fcnt == FW - 1) begin
          m_fd = 1; m_fcnt = 0; m_frames++;
        end else m_fcnt++;
      end
      if (in_trigger) begin
        if (full) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else mq.push_back(in_data);
      end
      m_trig = pop;
      m_last = pop;
    end
    #1;
    chk("out_trigger", 64'(out_trigger), 64'(m_trig));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("level", 64'(level), 64'(mq.size()));
    chk("in_busy", 64'(in_busy), 64'(mq.size() >= DEPTH - MARGIN));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
`ifdef STREAM_BRIDGE_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_frames[7:0]));
`endif
  endtask

  int pops, fd_n, last_s, strobes, gap_bad, guard;
  int fd_at[2];
  logic [DW-1:0] words[4];

  initial begin
    tbl[0] = '{2'd0, 32'h11223344, 32'h11223344};
    tbl[1] = '{2'd1, 32'h11223344, 32'h22114433};
    tbl[2] = '{2'd2, 32'h11223344, 32'h33441122};
    tbl[3] = '{2'd3, 32'h11223344, 32'h44332211};
    tbl[4] = '{2'd0, 32'hA1B2C3D4, 32'hA1B2C3D4};
    tbl[5] = '{2'd1, 32'hA1B2C3D4, 32'hB2A1D4C3};
    tbl[6] = '{2'd2, 32'hA1B2C3D4, 32'hC3D4A1B2};
    tbl[7] = '{2'd3, 32'hA1B2C3D4, 32'hD4C3B2A1};

    rst = 1; flush = 0; in_trigger = 0; out_busy = 0;
    swap_mode = 0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_trigger", 64'(out_trigger), 64'h0);
    chk("rst_in_busy", 64'(in_busy), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      swap_mode = tbl[i].m; in_data = tbl[i].d; in_trigger = 1;
      tick();
      chk("lat_early", 64'(out_trigger), 64'h0);
      in_trigger = 0;
      tick();
      chk("lat_trig", 64'(out_trigger), 64'h1);
      chk("swz_data", 64'(out_data), 64'(tbl[i].e));
      tick(); tick();
    end

    swap_mode = 0; out_busy = 1;
    for (int i = 1; i <= 17; i++) begin
      in_data = 32'h100 + i; in_trigger = 1;
      tick();
      if (i == 13) chk("busy_13", 64'(in_busy), 64'h0);
      if (i == 14) chk("busy_14", 64'(in_busy), 64'h1);
      if (i == 16) chk("ovf_16", 64'(overflow), 64'h0);
      if (i == 17) begin
        chk("ovf_17", 64'(overflow), 64'h1);
        chk("full_17", 64'(level), 64'd16);
      end
    end
    in_trigger = 0; out_busy = 0;
    guard = 0;
    while (mq.size() != 5 && guard < 100) begin
      tick(); guard++;
    end
    chk("drain_bound", 64'(guard < 100), 64'h1);
    out_busy = 1;
    tick();
    chk("lvl5", 64'(level), 64'd5);
    flush = 1; in_trigger = 1; in_data = 32'hDEAD;
    tick();
    flush = 0; in_trigger = 0;
    chk("flush_level", 64'(level), 64'h0);
    chk("flush_trig", 64'(out_trigger), 64'h0);
    chk("flush_ovf", 64'(overflow), 64'h0);
    out_busy = 0;
    tick();
    chk("flush_notrig", 64'(out_trigger), 64'h0);

    out_busy = 1;
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom; in_data = words[i]; in_trigger = 1;
      tick();
    end
    in_trigger = 0;
    strobes = 0; last_s = -100; gap_bad = 0;
    for (int c = 0; c < 60; c++) begin
      out_busy = (c % 10 != 9);
      tick();
      if (out_trigger) begin
        if (c - last_s < 2) gap_bad++;
        if (strobes < 4) chk("order", 64'(out_data), 64'(words[strobes]));
        last_s = c; strobes++;
      end
    end
    chk("strobes4", 64'(strobes), 64'd4);
    chk("gap", 64'(gap_bad), 64'd0);

    flush = 1; tick(); flush = 0;
    out_busy = 0; pops = 0; fd_n = 0;
    for (int i = 0; i < 30; i++) begin
      in_trigger = (i < 20); in_data = $urandom; swap_mode = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        tick();
        in_trigger = 0;
        if (out_trigger) pops++;
        if (frame_done) begin
          if (fd_n < 2) fd_at[fd_n] = pops;
          fd_n++;
        end
      end
    end
    chk("frame_pops", 64'(pops), 64'd20);
    chk("frame_pulses", 64'(fd_n), 64'd2);
    chk("frame_at0", 64'(fd_at[0]), 64'd8);
    chk("frame_at1", 64'(fd_at[1]), 64'd16);

    for (int c = 0; c < 600; c++) begin
      flush      = ($urandom_range(0, 63) == 0);
      in_trigger = ($urandom_range(0, 9) < 6);
      out_busy   = ($urandom_range(0, 9) < 3);
      swap_mode  = 2'($urandom);
      in_data    = $urandom;
      tick();
    end
    flush = 0; in_trigger = 0; out_busy = 0;
    repeat (40) tick();

    swap_mode = 0; in_data = 32'hCAFEF00D; in_trigger = 1;
    tick();
    in_trigger = 0;
    tick();
    chk("pre_rst_fire", 64'(out_trigger), 64'h1);
    #2 rst = 1;
    #1;
    chk("arst_trig", 64'(out_trigger), 64'h0);
    chk("arst_data", 64'(out_data), 64'h0);
    chk("arst_level", 64'(level), 64'h0);
    chk("arst_busy", 64'(in_busy), 64'h0);
    chk("arst_ovf", 64'(overflow), 64'h0);
    model_reset();
    tick();
    rst = 0;
    swap_mode = 3; in_data = 32'h11223344; in_trigger = 1;
    tick();
    in_trigger = 0;
    tick();
    chk("post_rst_trig", 64'(out_trigger), 64'h1);
    chk("post_rst_data", 64'(out_data), 64'h44332211);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
